// File: rtl/ram_stream_reader_pkg.sv
// ============================================================================
// ram_stream_reader_pkg : shared encodings and sizing for the matrix RAM clients
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam int FIFO_DEPTH = 4;

    // Address port width of the matrix RAM for a given ADDR_LEN.
    function automatic int ram_addr_w(input int addr_len);
        return addr_len + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_fifo.sv
// ============================================================================
// ram_rd_fifo : small synchronous FIFO with occupancy count, no bypass path
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_rd_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic             do_push_w;
    logic             do_pop_w;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop_w  = pop_i && (count_q != '0);
    assign do_push_w = push_i && ((count_q != CNTW'(DEPTH)) || do_pop_w);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_w) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop_w) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push_w, do_pop_w})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ram_stream_reader.sv
// ============================================================================
// ram_stream_reader : walks a (base, length) range of the matrix RAM and
// streams the words out on a valid/ready interface with backpressure.
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_LEN = 6,
    parameter int DATA_LEN = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_LEN+1:0]   base_addr,
    input  logic [ADDR_LEN+1:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_LEN+1:0]   rd_addr,
    input  logic [DATA_LEN-1:0]   ram_q,
    output logic [DATA_LEN-1:0]   m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int AW   = ram_addr_w(ADDR_LEN);
    localparam int CW   = ADDR_LEN + 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int OCCW = CNTW + 1;

    rd_state_e         state_q, state_d;
    logic [CW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     rem_q, rem_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              done_q, done_d;
    logic              v1_q, v2_q;
    logic              last1_q, last2_q;

    logic [DATA_LEN:0] fifo_head_w;
    logic [CNTW-1:0]   fifo_count_w;
    logic [OCCW-1:0]   occ_w;
    logic              pop_w;
    logic              slot_ok_w;
    logic              issue_w;
    logic              issue_last_w;
    logic              unused_base_msb_w;

    assign unused_base_msb_w = base_addr[AW-1];

    assign m_valid = (fifo_count_w != '0);
    assign pop_w   = m_valid && m_ready;

    // Words in the FIFO plus reads still in the RAM pipe must never exceed the depth.
    assign occ_w        = {1'b0, fifo_count_w} + OCCW'(v1_q) + OCCW'(v2_q);
    assign slot_ok_w    = occ_w < (OCCW'(FIFO_DEPTH) + OCCW'(pop_w));
    assign issue_w      = (state_q == ST_READ) && (rem_q != '0) && slot_ok_w;
    assign issue_last_w = issue_w && (rem_q == AW'(1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rd_addr_d = rd_addr_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        addr_d  = base_addr[CW-1:0];
                        rem_d   = length;
                    end
                end
            end
            ST_READ: begin
                if (issue_w) begin
                    rd_addr_d = {1'b0, addr_q};
                    addr_d    = addr_q + CW'(1);
                    rem_d     = rem_q - AW'(1);
                    if (issue_last_w) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop_w && fifo_head_w[DATA_LEN]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            last1_q   <= 1'b0;
            last2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            rd_addr_q <= rd_addr_d;
            done_q    <= done_d;
            v1_q      <= issue_w;
            last1_q   <= issue_last_w;
            v2_q      <= v1_q;
            last2_q   <= last1_q;
        end
    end

    ram_rd_fifo #(
        .WIDTH (DATA_LEN + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (v2_q),
        .push_data_i ({last2_q, ram_q}),
        .pop_i       (pop_w),
        .head_o      (fifo_head_w),
        .count_o     (fifo_count_w)
    );

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign rd_addr = rd_addr_q;
    assign m_data  = fifo_head_w[DATA_LEN-1:0];
    assign m_last  = fifo_head_w[DATA_LEN];

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// ============================================================================
// tb_ram_stream_reader : directed bench for ram_stream_reader with a RAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_stream_reader;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] length;
    logic       busy;
    logic       done;
    logic [7:0] rd_addr;
    logic [7:0] ram_q;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] mem   [128];
    logic [7:0] exp_d [16];

    ram_stream_reader #(.ADDR_LEN(6), .DATA_LEN(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .ram_q     (ram_q),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        ram_q <= mem[rd_addr[6:0]];
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic issue_cmd(input logic [7:0] b, input logic [7:0] n);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Consume a command's words, checking order, m_last and stall stability.
    task automatic collect(input int n_exp, input bit stall);
        int         idx   = 0;
        int         dones = 0;
        int         c     = 0;
        bit         was_stalled = 1'b0;
        logic [7:0] held  = '0;
        logic [7:0] addr_mark = '0;
        while (c < 200 && dones == 0) begin
            m_ready = stall ? (((c >= 6) && (c < 16)) ? 1'b0 : c[0]) : 1'b1;
            if (was_stalled) check("stall_hold", m_data, held);
            if (stall && c == 11) addr_mark = rd_addr;
            if (stall && c == 15) check("addr_stall", rd_addr, addr_mark);
            if (m_valid && m_ready) begin
                if (idx < n_exp) begin
                    check("word_data", m_data, exp_d[idx]);
                    check("word_last", m_last, (idx == n_exp - 1) ? 1 : 0);
                end else begin
                    check("extra_word", idx, n_exp);
                end
                idx++;
            end
            was_stalled = m_valid && !m_ready;
            held        = m_data;
            if (done) begin
                dones++;
                check("done_busy", busy, 0);
            end
            tick();
            c++;
        end
        m_ready = 1'b1;
        check("word_count", idx, n_exp);
        check("done_count", dones, 1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i + 16);
        RST       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b1;
        tick(); tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        RST = 1'b0;
        tick();

        // Streaming burst at full rate: latency and ordering.
        issue_cmd(8'd0, 8'd8);
        check("t1_busy", busy, 1);
        check("t1_valid_e0", m_valid, 0);
        tick();
        check("t1_addr_e1", rd_addr, 0);
        check("t1_valid_e1", m_valid, 0);
        tick();
        check("t1_addr_e2", rd_addr, 1);
        check("t1_valid_e2", m_valid, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t1_valid", m_valid, 1);
            check("t1_data", m_data, 32'h10 + i);
            check("t1_last", m_last, (i == 7) ? 1 : 0);
            check("t1_nodone", done, 0);
            tick();
        end
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_valid_end", m_valid, 0);
        tick();
        check("t1_done_pulse", done, 0);
        tick();

        // Backpressure with toggling ready and a long stall.
        for (int i = 0; i < 8; i++) exp_d[i] = 8'(8'h10 + i);
        issue_cmd(8'd0, 8'd8);
        collect(8, 1'b1);
        tick();

        // Address wrap at the top of the RAM.
        issue_cmd(8'd126, 8'd4);
        exp_d[0] = 8'h8E; exp_d[1] = 8'h8F; exp_d[2] = 8'h10; exp_d[3] = 8'h11;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 4) check("t3_addr", rd_addr, (c == 1) ? 126 : (c == 2) ? 127 : c - 3);
            if (c >= 3 && c <= 6) begin
                check("t3_data", m_data, exp_d[c-3]);
                check("t3_last", m_last, (c == 6) ? 1 : 0);
            end
        end
        check("t3_done", done, 1);
        tick();

        // Empty command.
        issue_cmd(8'd5, 8'd0);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_valid", m_valid, 0);
        tick();
        check("t4_done_pulse", done, 0);
        check("t4_valid2", m_valid, 0);
        tick(); tick();
        check("t4_valid3", m_valid, 0);

        // Start while busy is ignored.
        for (int i = 0; i < 4; i++) exp_d[i] = 8'(8'h10 + i);
        issue_cmd(8'd0, 8'd4);
        tick();
        base_addr = 8'h40;
        length    = 8'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        collect(4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("t5_no_done", done, 0);
            check("t5_no_valid", m_valid, 0);
            tick();
        end

        // Reset in the middle of a long command.
        issue_cmd(8'd0, 8'd16);
        tick(); tick();
        RST = 1'b1;
        tick();
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_addr", rd_addr, 0);
        check("t6_valid", m_valid, 0);
        check("t6_data", m_data, 0);
        check("t6_last", m_last, 0);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_quiet_done", done, 0);
            check("t6_quiet_valid", m_valid, 0);
        end
        for (int i = 0; i < 3; i++) exp_d[i] = 8'(8'h30 + i);
        issue_cmd(8'h20, 8'd3);
        collect(3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
